// File: rtl/i2c_modport_pkg.sv
`default_nettype none
// ============================================================================
// Module      : i2c_modport_pkg
// Description : Shared types, constants and bus-drive helper for i2c_modport.
// Revision    : 1.0 - initial release
// ============================================================================
package i2c_modport_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        START = 4'd1,
        ADDR  = 4'd2,
        AACK  = 4'd3,
        WR    = 4'd4,
        WACK  = 4'd5,
        RD    = 4'd6,
        MNACK = 4'd7,
        STOP  = 4'd8,
        DONE  = 4'd9
    } state_e;

    localparam logic I2C_ACK   = 1'b0;
    localparam logic I2C_NACK  = 1'b1;
    localparam int   BYTE_BITS = 8;

    // Returns {scl, sda_oe} for a given state and quarter of the bit slot.
    function automatic logic [1:0] bus_drive(input state_e st, input logic [1:0] qtr,
                                             input logic tx_bit);
        logic scl;
        logic oe;
        scl = 1'b1;
        oe  = 1'b0;
        case (st)
            START:                 oe = qtr[1];
            ADDR, WR: begin
                scl = qtr[1];
                oe  = ~tx_bit;
            end
            AACK, WACK, RD, MNACK: scl = qtr[1];
            STOP: begin
                scl = (qtr != 2'd0);
                oe  = (qtr != 2'd3);
            end
            default: ;
        endcase
        return {scl, oe};
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_modport_tick.sv
`default_nettype none
// ============================================================================
// Module      : i2c_modport_tick
// Description : Quarter-period timebase; pulses on the last cycle of a quarter.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_modport_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       s_reset,
    input  logic       clear_i,
    output logic       tick_o,
    output logic [1:0] quarter_o
);

    localparam int                 c_cnt_w   = $clog2(CLK_DIV);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(CLK_DIV - 1);

    logic [c_cnt_w-1:0] r_cnt_q;
    logic [1:0]         r_qtr_q;

    always_ff @(posedge clk) begin
        if (s_reset || clear_i) begin
            r_cnt_q <= '0;
            r_qtr_q <= 2'd0;
        end else if (r_cnt_q == c_cnt_max) begin
            r_cnt_q <= '0;
            r_qtr_q <= r_qtr_q + 2'd1;
        end else begin
            r_cnt_q <= r_cnt_q + 1'b1;
        end
    end

    assign tick_o    = (r_cnt_q == c_cnt_max);
    assign quarter_o = r_qtr_q;

endmodule
`default_nettype wire

// File: rtl/i2c_modport.sv
`default_nettype none
// ============================================================================
// Module      : i2c_modport
// Description : Single-master I2C controller, one single-byte transfer per command.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_modport
    import i2c_modport_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       s_reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    output logic       i2c_scl,
    output logic       sda_o,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam logic [2:0] c_bit_last = 3'(BYTE_BITS - 1);

    state_e               r_state_q, w_state_d;
    logic [2:0]           r_bit_q, w_bit_d;
    logic [BYTE_BITS-1:0] r_tx_q, w_tx_d;
    logic [BYTE_BITS-1:0] r_wdata_q, w_wdata_d;
    logic [BYTE_BITS-1:0] r_rdata_q, w_rdata_d;
    logic                 r_rw_q, w_rw_d;
    logic                 r_nack_q, w_nack_d;
    logic                 r_scl_q, r_oe_q, r_ready_q, r_busy_q, r_rspv_q;

    logic       w_tick;
    logic       w_tick_clr;
    logic [1:0] w_qtr, w_qtr_d;
    logic       w_slot_end;
    logic       w_sample;
    logic [1:0] w_drive;

    assign w_tick_clr = (r_state_q == IDLE) || (r_state_q == DONE);

    i2c_modport_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk       (clk),
        .s_reset   (s_reset),
        .clear_i   (w_tick_clr),
        .tick_o    (w_tick),
        .quarter_o (w_qtr)
    );

    assign w_slot_end = w_tick && (w_qtr == 2'd3);
    assign w_sample   = w_tick && (w_qtr == 2'd2);
    assign w_qtr_d    = w_tick ? (w_qtr + 2'd1) : w_qtr;

    always_comb begin
        w_state_d = r_state_q;
        w_bit_d   = r_bit_q;
        w_tx_d    = r_tx_q;
        w_wdata_d = r_wdata_q;
        w_rdata_d = r_rdata_q;
        w_rw_d    = r_rw_q;
        w_nack_d  = r_nack_q;
        case (r_state_q)
            IDLE: begin
                if (cmd_valid && r_ready_q) begin
                    w_state_d = START;
                    w_tx_d    = {cmd_addr, cmd_rw};
                    w_wdata_d = cmd_wdata;
                    w_rw_d    = cmd_rw;
                    w_rdata_d = '0;
                    w_nack_d  = 1'b0;
                    w_bit_d   = 3'd0;
                end
            end
            START: if (w_slot_end) w_state_d = ADDR;
            ADDR, WR: begin
                if (w_slot_end) begin
                    w_tx_d = {r_tx_q[BYTE_BITS-2:0], 1'b0};
                    if (r_bit_q == c_bit_last) begin
                        w_bit_d   = 3'd0;
                        w_state_d = (r_state_q == ADDR) ? AACK : WACK;
                    end else begin
                        w_bit_d = r_bit_q + 3'd1;
                    end
                end
            end
            AACK: begin
                if (w_sample && (sda_i == I2C_NACK)) w_nack_d = 1'b1;
                if (w_slot_end) begin
                    if (r_nack_q) begin
                        w_state_d = STOP;
                    end else if (r_rw_q) begin
                        w_state_d = RD;
                    end else begin
                        w_state_d = WR;
                        w_tx_d    = r_wdata_q;
                    end
                end
            end
            WACK: begin
                if (w_sample && (sda_i == I2C_NACK)) w_nack_d = 1'b1;
                if (w_slot_end) w_state_d = STOP;
            end
            RD: begin
                if (w_sample) w_rdata_d = {r_rdata_q[BYTE_BITS-2:0], sda_i};
                if (w_slot_end) begin
                    if (r_bit_q == c_bit_last) begin
                        w_bit_d   = 3'd0;
                        w_state_d = MNACK;
                    end else begin
                        w_bit_d = r_bit_q + 3'd1;
                    end
                end
            end
            MNACK:   if (w_slot_end) w_state_d = STOP;
            STOP:    if (w_slot_end) w_state_d = DONE;
            DONE:    w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // Pin values are computed from the next state/quarter so they can be registered.
    assign w_drive = bus_drive(w_state_d, w_qtr_d, w_tx_d[BYTE_BITS-1]);

    always_ff @(posedge clk) begin
        if (s_reset) begin
            r_state_q <= IDLE;
            r_bit_q   <= 3'd0;
            r_tx_q    <= '0;
            r_wdata_q <= '0;
            r_rdata_q <= '0;
            r_rw_q    <= 1'b0;
            r_nack_q  <= 1'b0;
            r_scl_q   <= 1'b1;
            r_oe_q    <= 1'b0;
            r_ready_q <= 1'b1;
            r_busy_q  <= 1'b0;
            r_rspv_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_bit_q   <= w_bit_d;
            r_tx_q    <= w_tx_d;
            r_wdata_q <= w_wdata_d;
            r_rdata_q <= w_rdata_d;
            r_rw_q    <= w_rw_d;
            r_nack_q  <= w_nack_d;
            r_scl_q   <= w_drive[1];
            r_oe_q    <= w_drive[0];
            r_ready_q <= (w_state_d == IDLE);
            r_busy_q  <= (w_state_d != IDLE);
            r_rspv_q  <= (w_state_d == DONE);
        end
    end

    assign cmd_ready = r_ready_q;
    assign busy      = r_busy_q;
    assign rsp_valid = r_rspv_q;
    assign rsp_rdata = r_rdata_q;
    assign rsp_nack  = r_nack_q;
    assign i2c_scl   = r_scl_q;
    assign sda_oe    = r_oe_q;
    assign sda_o     = 1'b0;

endmodule
`default_nettype wire

// File: tb/tb_i2c_modport.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_modport
// Description : Self-checking bench with a behavioural I2C slave and scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_modport;

    localparam int CLK_DIV   = 4;
    localparam int LAT_FULL  = 80 * CLK_DIV + 1;
    localparam int LAT_ANACK = 44 * CLK_DIV + 1;
    localparam int TIMEOUT   = 2000;

    logic       clk = 1'b0;
    logic       s_reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_rw = 1'b0;
    logic [6:0] cmd_addr = 7'h00;
    logic [7:0] cmd_wdata = 8'h00;
    logic       cmd_ready, rsp_valid, rsp_nack, busy, i2c_scl, sda_o, sda_oe, sda_i;
    logic [7:0] rsp_rdata;
    logic       slave_sda = 1'b1;

    assign sda_i = (sda_oe ? sda_o : 1'b1) & slave_sda;

    i2c_modport #(.CLK_DIV(CLK_DIV)) dut (
        .clk       (clk),
        .s_reset   (s_reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_rw    (cmd_rw),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_nack  (rsp_nack),
        .busy      (busy),
        .i2c_scl   (i2c_scl),
        .sda_o     (sda_o),
        .sda_oe    (sda_oe),
        .sda_i     (sda_i)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        logic [6:0] sl_addr;
        logic       sl_dnack;
        logic [7:0] sl_rdata;
        logic       exp_nack;
        logic [7:0] exp_rdata;
        int         exp_lat;
    } vec_t;

    typedef struct {
        logic       nack;
        logic [7:0] rdata;
        int         lat;
        int         acc_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t cur_exp;
    exp_t mon_e;
    vec_t vecs[7];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int rsp_cnt = 0;
    int acc_cnt = 0;
    int last_rsp_cyc = 0;
    int last_acc_cyc = 0;

    // slave configuration and observations
    logic [6:0] sl_addr = 7'h50;
    logic       sl_dnack = 1'b0;
    logic [7:0] sl_rdata = 8'h00;
    logic [7:0] cap_addr = 8'h00;
    logic [7:0] cap_data = 8'h00;
    logic       cap_mnack = 1'b0;
    int         stop_cnt = 0;
    int         stop_rises = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: timeout after %0d cycles", name, TIMEOUT);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!s_reset && cmd_valid && cmd_ready) begin
            mon_e         = cur_exp;
            mon_e.acc_cyc = cyc;
            sb_q.push_back(mon_e);
            acc_cnt++;
            last_acc_cyc = cyc;
        end
        if (rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got rsp_valid with empty scoreboard");
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_nack", 32'(rsp_nack), 32'(mon_e.nack));
                check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                check("rsp_latency", cyc - mon_e.acc_cyc, mon_e.lat);
                check("busy_at_rsp", 32'(busy), 32'd1);
            end
        end
    end

    // behavioural slave: samples on SCL rise, changes SDA after SCL fall
    logic       prev_scl = 1'b1, prev_sda = 1'b1, cur_scl, cur_sda;
    logic       sl_active = 1'b0, addr_ack = 1'b0, sl_read = 1'b0;
    logic [7:0] ash = 8'h00, dsh = 8'h00;
    logic [2:0] bidx;
    int         rises = 0;

    always @(negedge clk) begin
        cur_scl = i2c_scl;
        cur_sda = sda_i;
        if (s_reset) begin
            slave_sda = 1'b1;
            sl_active = 1'b0;
            rises     = 0;
        end else if (prev_scl && cur_scl && prev_sda && !cur_sda) begin
            sl_active = 1'b1;
            rises     = 0;
            slave_sda = 1'b1;
        end else if (prev_scl && cur_scl && !prev_sda && cur_sda) begin
            if (sl_active) begin
                stop_cnt++;
                stop_rises = rises;
            end
            sl_active = 1'b0;
            slave_sda = 1'b1;
        end else if (sl_active && !prev_scl && cur_scl) begin
            rises++;
            if (rises <= 8) ash = {ash[6:0], cur_sda};
            if (rises == 8) begin
                cap_addr = ash;
                addr_ack = (ash[7:1] == sl_addr);
                sl_read  = ash[0];
            end
            if (rises >= 10 && rises <= 17) dsh = {dsh[6:0], cur_sda};
            if (rises == 17) cap_data = dsh;
            if (rises == 18) cap_mnack = cur_sda;
        end else if (sl_active && prev_scl && !cur_scl) begin
            if (rises == 8) begin
                slave_sda = addr_ack ? 1'b0 : 1'b1;
            end else if (rises >= 9 && rises <= 16 && addr_ack && sl_read) begin
                bidx      = 3'(16 - rises);
                slave_sda = sl_rdata[bidx];
            end else if (rises == 17 && addr_ack && !sl_read) begin
                slave_sda = sl_dnack;
            end else begin
                slave_sda = 1'b1;
            end
        end
        prev_scl = cur_scl;
        prev_sda = cur_sda;
    end

    task automatic run_vec(input vec_t v, input string tag);
        int   k;
        int   n0;
        int   s0;
        logic acked;
        acked = (v.addr == v.sl_addr);
        @(posedge clk);
        #1;
        sl_addr       = v.sl_addr;
        sl_dnack      = v.sl_dnack;
        sl_rdata      = v.sl_rdata;
        cur_exp.nack  = v.exp_nack;
        cur_exp.rdata = v.exp_rdata;
        cur_exp.lat   = v.exp_lat;
        cmd_rw        = v.rw;
        cmd_addr      = v.addr;
        cmd_wdata     = v.wdata;
        cmd_valid     = 1'b1;
        n0            = rsp_cnt;
        s0            = stop_cnt;
        k = 0;
        while (!cmd_ready && k < TIMEOUT) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= TIMEOUT) timeout_fail({tag, "_accept"});
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
        check({tag, "_ready_after_accept"}, 32'(cmd_ready), 32'd0);
        k = 0;
        while (rsp_cnt == n0 && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        if (k >= TIMEOUT) timeout_fail({tag, "_rsp"});
        @(posedge clk);
        #1;
        check({tag, "_ready_after_rsp"}, 32'(cmd_ready), 32'd1);
        check({tag, "_busy_after_rsp"}, 32'(busy), 32'd0);
        check({tag, "_stop_seen"}, stop_cnt - s0, 1);
        check({tag, "_addr_byte"}, 32'(cap_addr), 32'({v.addr, v.rw}));
        check({tag, "_scl_rises"}, stop_rises, acked ? 19 : 10);
        if (acked && !v.rw) check({tag, "_wdata_byte"}, 32'(cap_data), 32'(v.wdata));
        if (acked && v.rw) check({tag, "_master_nack"}, 32'(cap_mnack), 32'd1);
    endtask

    initial begin
        int viol;
        int k;
        int a0;
        int r0;

        vecs[0] = '{1'b0, 7'h50, 8'hA5, 7'h50, 1'b0, 8'h00, 1'b0, 8'h00, LAT_FULL};
        vecs[1] = '{1'b1, 7'h50, 8'h00, 7'h50, 1'b0, 8'h3C, 1'b0, 8'h3C, LAT_FULL};
        vecs[2] = '{1'b1, 7'h21, 8'h00, 7'h50, 1'b0, 8'h3C, 1'b1, 8'h00, LAT_ANACK};
        vecs[3] = '{1'b0, 7'h21, 8'h5A, 7'h50, 1'b0, 8'h00, 1'b1, 8'h00, LAT_ANACK};
        vecs[4] = '{1'b0, 7'h50, 8'h00, 7'h50, 1'b1, 8'h00, 1'b1, 8'h00, LAT_FULL};
        vecs[5] = '{1'b1, 7'h7F, 8'h00, 7'h7F, 1'b0, 8'hFF, 1'b0, 8'hFF, LAT_FULL};
        vecs[6] = '{1'b0, 7'h01, 8'h81, 7'h01, 1'b0, 8'h00, 1'b0, 8'h00, LAT_FULL};

        // reset state
        s_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        s_reset = 1'b0;
        check("rst_scl", 32'(i2c_scl), 32'd1);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_sda_o", 32'(sda_o), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rdata", 32'(rsp_rdata), 32'd0);
        check("rst_nack", 32'(rsp_nack), 32'd0);
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (i2c_scl !== 1'b1 || sda_oe !== 1'b0 || busy !== 1'b0 ||
                cmd_ready !== 1'b1 || rsp_valid !== 1'b0) viol++;
        end
        check("idle_quiet", viol, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // cmd_valid held through a whole transaction
        @(posedge clk);
        #1;
        sl_addr       = 7'h50;
        sl_dnack      = 1'b0;
        cur_exp.nack  = 1'b0;
        cur_exp.rdata = 8'h00;
        cur_exp.lat   = LAT_FULL;
        cmd_rw        = 1'b0;
        cmd_addr      = 7'h50;
        cmd_wdata     = 8'hA5;
        cmd_valid     = 1'b1;
        a0 = acc_cnt;
        r0 = rsp_cnt;
        k = 0;
        while (rsp_cnt == r0 && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        if (k >= TIMEOUT) timeout_fail("held_rsp1");
        check("held_single_accept", acc_cnt - a0, 1);
        k = 0;
        while (acc_cnt < a0 + 2 && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        if (k >= TIMEOUT) timeout_fail("held_accept2");
        check("held_b2b_accept_cycle", last_acc_cyc - last_rsp_cyc, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        k = 0;
        while (rsp_cnt < r0 + 2 && k < TIMEOUT) begin
            @(negedge clk);
            k++;
        end
        if (k >= TIMEOUT) timeout_fail("held_rsp2");
        check("held_total_accepts", acc_cnt - a0, 2);

        // reset during the address phase
        @(posedge clk);
        #1;
        cur_exp.nack  = 1'b0;
        cur_exp.rdata = 8'h00;
        cur_exp.lat   = LAT_FULL;
        cmd_rw        = 1'b0;
        cmd_addr      = 7'h50;
        cmd_wdata     = 8'h3C;
        cmd_valid     = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (4 * CLK_DIV * 3) @(posedge clk);
        #1;
        check("abort_busy_before", 32'(busy), 32'd1);
        s_reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_scl", 32'(i2c_scl), 32'd1);
        check("abort_sda_oe", 32'(sda_oe), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        s_reset = 1'b0;
        sb_q.delete();
        run_vec(vecs[0], "after_abort");

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
